// File: rtl/opacc_seq.sv
// rtl/opacc_seq.sv - outer-product accumulator tile sequencer (load C, MAC over k steps, drain C)
//
// Purpose: steps an ML-row outer-product array through one tile command.
//   LOAD  : shift ML rows into the accumulators, either zeros or rows from the C input stream
//   MAC   : apply cmd_k A/B outer-product steps as the operand stream presents them
//   DRAIN : shift ML result rows out to the C output stream, zero-filling behind them
//   FLUSH : wait for the last result row to be taken, then pulse done
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   start_valid/start_ready         tile command handshake
//   cmd_k, cmd_zero                 MAC step count, zero-initialise select
//   cmd_sgn_a, cmd_sgn_b            operand signedness
//   ab_valid/ab_ready               A/B operand stream handshake
//   c_in_valid/c_in_ready           C-row input stream handshake
//   c_out_valid/c_out_ready         C-row result stream handshake
//   en_ab, en_c, c_zero             array step enable, row-shift enable, zero-select for C input mux
//   issng_a, issng_b                signedness to the array
//   busy, done                      busy level, single-cycle completion pulse

module opacc_seq #(
  parameter int ML = 4,
  parameter int KW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_valid,
  output logic          start_ready,
  input  logic [KW-1:0] cmd_k,
  input  logic          cmd_zero,
  input  logic          cmd_sgn_a,
  input  logic          cmd_sgn_b,
  input  logic          ab_valid,
  output logic          ab_ready,
  input  logic          c_in_valid,
  output logic          c_in_ready,
  output logic          c_out_valid,
  input  logic          c_out_ready,
  output logic          en_ab,
  output logic          en_c,
  output logic          c_zero,
  output logic          issng_a,
  output logic          issng_b,
  output logic          busy,
  output logic          done
);

  localparam int RW = $clog2(ML + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MAC   = 3'd2,
    DRAIN = 3'd3,
    FLUSH = 3'd4
  } state_t;

  state_t        state;
  logic [KW-1:0] k_rem;     // MAC steps still to accept; counts down so max k never wraps
  logic [RW-1:0] row_cnt;   // rows shifted in the current LOAD or DRAIN pass
  logic          zero_lat;
  logic          sgn_a_lat;
  logic          sgn_b_lat;
  logic          out_vld;
  logic          done_q;
  logic          slot_free;
  logic          last_row;

  // The output register can take a new row when empty or being emptied this cycle.
  assign slot_free = !out_vld || c_out_ready;
  assign last_row  = (row_cnt == RW'(ML - 1));

  // Gated with rst_n so start_ready is low while reset is held and high as soon as it lifts.
  assign start_ready = rst_n && (state == IDLE);
  assign ab_ready    = (state == MAC);
  assign c_in_ready  = (state == LOAD) && !zero_lat;
  assign en_ab       = (state == MAC) && ab_valid;
  // LOAD and DRAIN are exclusive of MAC, so en_c and en_ab can never coincide.
  assign en_c        = ((state == LOAD) && (zero_lat || c_in_valid)) ||
                       ((state == DRAIN) && slot_free);
  assign c_zero      = ((state == LOAD) && zero_lat) || (state == DRAIN);
  assign busy        = (state != IDLE);
  assign issng_a     = sgn_a_lat;
  assign issng_b     = sgn_b_lat;
  assign c_out_valid = out_vld;
  assign done        = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k_rem     <= '0;
      row_cnt   <= '0;
      zero_lat  <= 1'b0;
      sgn_a_lat <= 1'b0;
      sgn_b_lat <= 1'b0;
      out_vld   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // The array output is registered: a row appears the cycle after its DRAIN shift.
      if ((state == DRAIN) && slot_free) begin
        out_vld <= 1'b1;
      end else if (c_out_ready) begin
        out_vld <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start_valid) begin
            k_rem     <= cmd_k;
            zero_lat  <= cmd_zero;
            sgn_a_lat <= cmd_sgn_a;
            sgn_b_lat <= cmd_sgn_b;
            row_cnt   <= '0;
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (en_c) begin
            if (last_row) begin
              row_cnt <= '0;
              state   <= (k_rem != '0) ? MAC : DRAIN;
            end else begin
              row_cnt <= row_cnt + RW'(1);
            end
          end
        end
        MAC: begin
          if (ab_valid) begin
            k_rem <= k_rem - KW'(1);
            if (k_rem == KW'(1)) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (slot_free) begin
            if (last_row) begin
              row_cnt <= '0;
              state   <= FLUSH;
            end else begin
              row_cnt <= row_cnt + RW'(1);
            end
          end
        end
        FLUSH: begin
          if (slot_free) begin
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_opacc_seq.sv
// tb/tb_opacc_seq.sv - directed table-driven bench for opacc_seq

module tb_opacc_seq;

  localparam int ML = 4;
  localparam int KW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_valid;
  logic          start_ready;
  logic [KW-1:0] cmd_k;
  logic          cmd_zero;
  logic          cmd_sgn_a;
  logic          cmd_sgn_b;
  logic          ab_valid;
  logic          ab_ready;
  logic          c_in_valid;
  logic          c_in_ready;
  logic          c_out_valid;
  logic          c_out_ready;
  logic          en_ab;
  logic          en_c;
  logic          c_zero;
  logic          issng_a;
  logic          issng_b;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  opacc_seq #(.ML(ML), .KW(KW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .cmd_k       (cmd_k),
    .cmd_zero    (cmd_zero),
    .cmd_sgn_a   (cmd_sgn_a),
    .cmd_sgn_b   (cmd_sgn_b),
    .ab_valid    (ab_valid),
    .ab_ready    (ab_ready),
    .c_in_valid  (c_in_valid),
    .c_in_ready  (c_in_ready),
    .c_out_valid (c_out_valid),
    .c_out_ready (c_out_ready),
    .en_ab       (en_ab),
    .en_c        (en_c),
    .c_zero      (c_zero),
    .issng_a     (issng_a),
    .issng_b     (issng_b),
    .busy        (busy),
    .done        (done)
  );

  typedef struct {
    int k;
    bit zero;
    bit sa;
    bit sb;
    bit tog;       // c_in_valid high on odd cycles only
    int stall_lo;  // c_out_ready low for cycles stall_lo..stall_hi after the handshake
    int stall_hi;
    int exp_ab;
    int exp_cin;   // en_c while c_in_ready
    int exp_lat;   // cycles from start handshake to done
  } vec_t;

  vec_t vecs[6];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int outs_vec();
    return {20'd0, en_ab, en_c, c_zero, c_out_valid, done, busy,
            ab_ready, c_in_ready, issng_a, issng_b, start_ready};
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int n_enc = 0, n_ab = 0, n_rows = 0, n_ovl = 0, n_sgn = 0;
    int n_cin = 0, n_cinbad = 0, n_stall = 0, n_srdy = 0, lat = -1;
    @(posedge clk); #1;
    start_valid = 1'b1;
    cmd_k       = v.k[KW-1:0];
    cmd_zero    = v.zero;
    cmd_sgn_a   = v.sa;
    cmd_sgn_b   = v.sb;
    ab_valid    = 1'b1;
    c_in_valid  = 1'b1;
    c_out_ready = 1'b1;
    #1;
    chk($sformatf("v%0d start_ready", idx), int'(start_ready), 1);
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk); #1;
      // Command inputs change and start_valid stays up early on: none of it may be latched.
      start_valid = (c <= 5);
      cmd_k       = ~v.k[KW-1:0];
      cmd_zero    = !v.zero;
      cmd_sgn_a   = !v.sa;
      cmd_sgn_b   = !v.sb;
      c_in_valid  = v.tog ? c[0] : 1'b1;
      c_out_ready = !(c >= v.stall_lo && c <= v.stall_hi);
      #1;
      if (en_c) n_enc++;
      if (en_ab) n_ab++;
      if (c_out_valid && c_out_ready) n_rows++;
      if (en_c && en_ab) n_ovl++;
      if (busy && (issng_a != v.sa || issng_b != v.sb)) n_sgn++;
      if (en_c && c_in_ready) n_cin++;
      if (en_c && c_in_ready && !c_in_valid) n_cinbad++;
      if (c >= v.stall_lo && c <= v.stall_hi && (en_c || !c_out_valid)) n_stall++;
      if (busy && start_ready) n_srdy++;
      if (done) begin
        lat = c;
        break;
      end
    end
    start_valid = 1'b0;
    chk($sformatf("v%0d done_latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d en_ab_count", idx), n_ab, v.exp_ab);
    chk($sformatf("v%0d en_c_count", idx), n_enc, 2 * ML);
    chk($sformatf("v%0d c_out_rows", idx), n_rows, ML);
    chk($sformatf("v%0d en_overlap", idx), n_ovl, 0);
    chk($sformatf("v%0d issng_held", idx), n_sgn, 0);
    chk($sformatf("v%0d load_stream_en_c", idx), n_cin, v.exp_cin);
    chk($sformatf("v%0d en_c_without_c_in_valid", idx), n_cinbad, 0);
    chk($sformatf("v%0d stall_hold", idx), n_stall, 0);
    chk($sformatf("v%0d start_ready_while_busy", idx), n_srdy, 0);
    @(posedge clk); #2;
    chk($sformatf("v%0d done_pulse_end", idx), int'(done), 0);
    chk($sformatf("v%0d idle_after", idx), int'(busy), 0);
  endtask

  initial begin
    int n_done;
    //          k    z  sa sb tog slo shi ab   cin lat
    vecs[0] = '{3,   1, 0, 0, 0,  1,  0,  3,   0,  13};
    vecs[1] = '{0,   1, 0, 1, 0,  1,  0,  0,   0,  10};
    vecs[2] = '{5,   0, 1, 0, 1,  1,  0,  5,   4,  18};
    vecs[3] = '{1,   0, 1, 1, 0,  1,  0,  1,   4,  11};
    vecs[4] = '{0,   1, 0, 0, 0,  7,  11, 0,   0,  15};
    vecs[5] = '{255, 1, 1, 0, 0,  1,  0,  255, 0,  265};

    rst_n       = 1'b0;
    start_valid = 1'b1;
    cmd_k       = '1;
    cmd_zero    = 1'b1;
    cmd_sgn_a   = 1'b1;
    cmd_sgn_b   = 1'b1;
    ab_valid    = 1'b1;
    c_in_valid  = 1'b1;
    c_out_ready = 1'b1;
    #22;
    chk("reset_outputs", outs_vec(), 0);
    start_valid = 1'b0;
    rst_n       = 1'b1;
    #1;
    chk("start_ready_after_reset", int'(start_ready), 1);
    chk("busy_after_reset", int'(busy), 0);

    for (int i = 0; i < 6; i++) begin
      run_vec(i, vecs[i]);
    end

    // Reset during MAC step 2 of 5: LOAD is cycles 1..4, MAC step 2 is cycle 6.
    @(posedge clk); #1;
    start_valid = 1'b1;
    cmd_k       = KW'(5);
    cmd_zero    = 1'b1;
    cmd_sgn_a   = 1'b1;
    cmd_sgn_b   = 1'b1;
    ab_valid    = 1'b1;
    c_out_ready = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      start_valid = 1'b0;
    end
    #1;
    chk("mid_mac_en_ab", int'(en_ab), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_mac_reset_outputs", outs_vec(), 0);
    @(posedge clk); #3;
    chk("reset_held_outputs", outs_vec(), 0);
    rst_n = 1'b1;
    #1;
    chk("mid_mac_start_ready", int'(start_ready), 1);
    n_done = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #2;
      if (done || busy) n_done++;
    end
    chk("mid_mac_no_done", n_done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
